// File: rtl/beta_lifo_if.sv
// beta_lifo_if: branch-metric input handshake plus the beta state-metric
// output bundle of the backward-recursion unit.
// master = upstream/consumer side, slave = beta_lifo itself.
interface beta_lifo_if #(
  parameter int ADDR_W = 13
);
  logic               valid_branch;
  logic signed [15:0] init_branch1;
  logic signed [15:0] init_branch2;
  logic               last_branch;
  logic               ready_in;
  logic signed [15:0] beta_0;
  logic signed [15:0] beta_1;
  logic signed [15:0] beta_2;
  logic signed [15:0] beta_3;
  logic signed [15:0] beta_4;
  logic signed [15:0] beta_5;
  logic signed [15:0] beta_6;
  logic signed [15:0] beta_7;
  logic [ADDR_W-1:0]  beta_idx;
  logic               valid_beta;
  logic               last_beta;
  logic               overflow;

  modport master (
    output valid_branch, init_branch1, init_branch2, last_branch,
    input  ready_in, beta_0, beta_1, beta_2, beta_3, beta_4, beta_5, beta_6,
           beta_7, beta_idx, valid_beta, last_beta, overflow
  );

  modport slave (
    input  valid_branch, init_branch1, init_branch2, last_branch,
    output ready_in, beta_0, beta_1, beta_2, beta_3, beta_4, beta_5, beta_6,
           beta_7, beta_idx, valid_beta, last_beta, overflow
  );
endinterface

// File: rtl/beta_lifo.sv
// beta_lifo: backward (beta) recursion of the max-log-MAP SISO decoder.
// Branch-metric pairs of one block are pushed into a LIFO; on the last step
// they are replayed in reverse through the 8-state beta recursion and one
// state-metric vector per trellis step is emitted with its step index.
// Optional feature macro: BETA_NORM_EN -- subtract the new b0 from all eight
// metrics every step (stored b0 stays 0). Undefined: raw wrapping metrics.
module beta_lifo #(
  parameter int MAX_LEN = 6144,
  parameter int ADDR_W  = 13
) (
  input  logic       clk,
  input  logic       rst,
  beta_lifo_if.slave bus
);
  localparam int DATA_W = 16;
  localparam logic signed [DATA_W-1:0] INIT_NEG = -16'sd128;

  typedef logic signed [DATA_W-1:0] metric_t;
  typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2*DATA_W-1:0] r_mem [MAX_LEN];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic                r_overflow;
  logic                w_accept;
  logic                w_full;
  logic                w_close;

  logic [2*DATA_W-1:0] r_rd_p0;
  logic                r_vld_p0;
  logic                r_last_p0;
  logic [ADDR_W-1:0]   r_idx_p0;

  metric_t             r_b [8];
  metric_t             w_raw [8];
  metric_t             w_b_nxt [8];
  metric_t             w_g1;
  metric_t             w_g2;

  metric_t             r_beta_p1 [8];
  logic [ADDR_W-1:0]   r_idx_p1;
  logic                r_vld_p1;
  logic                r_last_p1;

  // Strict signed compare; a tie selects the second term.
  function automatic metric_t max2(input metric_t a, input metric_t b);
    return (a > b) ? a : b;
  endfunction

  assign w_accept = bus.valid_branch && (r_state == FILL);
  assign w_full   = (r_wr_ptr == ADDR_W'(MAX_LEN - 1));
  assign w_close  = w_accept && (bus.last_branch || w_full);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FILL;
    else      r_state <= w_next;
  end

  // Next state: FILL until the closing accept, DRAIN while reads are issued,
  // FLUSH until the k = 0 output has left the pipeline.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_close) w_next = DRAIN;
      DRAIN:   if (r_rd_ptr == '0) w_next = FLUSH;
      FLUSH:   if (r_last_p1) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // Write/read pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_close) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= r_wr_ptr;
          if (w_full && !bus.last_branch) r_overflow <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        end
      end
      if (r_state == DRAIN && r_rd_ptr != '0) r_rd_ptr <= r_rd_ptr - ADDR_W'(1);
    end
  end

  // LIFO storage write port.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= {bus.init_branch1, bus.init_branch2};
  end

  // ---- stage p0: synchronous RAM read, one address per DRAIN cycle ----
  always_ff @(posedge clk) begin
    if (r_state == DRAIN) r_rd_p0 <= r_mem[r_rd_ptr];
  end

  // Control that travels with the read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_idx_p0  <= '0;
    end else begin
      r_vld_p0  <= (r_state == DRAIN);
      r_last_p0 <= (r_state == DRAIN) && (r_rd_ptr == '0);
      r_idx_p0  <= r_rd_ptr;
    end
  end

  // Butterfly update of the beta register from the replayed gammas.
  always_comb begin
    w_g1     = r_rd_p0[2*DATA_W-1:DATA_W];
    w_g2     = r_rd_p0[DATA_W-1:0];
    w_raw[0] = max2(r_b[0] + w_g1, r_b[4] - w_g1);
    w_raw[1] = max2(r_b[0] - w_g1, r_b[4] + w_g1);
    w_raw[2] = max2(r_b[1] - w_g2, r_b[5] + w_g2);
    w_raw[3] = max2(r_b[1] + w_g2, r_b[5] - w_g2);
    w_raw[4] = max2(r_b[2] + w_g2, r_b[6] - w_g2);
    w_raw[5] = max2(r_b[2] - w_g2, r_b[6] + w_g2);
    w_raw[6] = max2(r_b[3] - w_g1, r_b[7] + w_g1);
    w_raw[7] = max2(r_b[3] + w_g1, r_b[7] - w_g1);
    for (int i = 0; i < 8; i++) begin
`ifdef BETA_NORM_EN
      w_b_nxt[i] = w_raw[i] - w_raw[0];
`else
      w_b_nxt[i] = w_raw[i];
`endif
    end
  end

  // Beta register: terminated-trellis init on block close, update per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) r_b[i] <= (i == 0) ? '0 : INIT_NEG;
    end else if (w_close) begin
      for (int i = 0; i < 8; i++) r_b[i] <= (i == 0) ? '0 : INIT_NEG;
    end else if (r_vld_p0) begin
      for (int i = 0; i < 8; i++) r_b[i] <= w_b_nxt[i];
    end
  end

  // ---- stage p1: output register, emits beta_{k+1} tagged with k ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_idx_p1  <= '0;
      for (int i = 0; i < 8; i++) r_beta_p1[i] <= '0;
    end else begin
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
      if (r_vld_p0) begin
        r_idx_p1 <= r_idx_p0;
        for (int i = 0; i < 8; i++) r_beta_p1[i] <= r_b[i];
      end
    end
  end

  assign bus.ready_in   = (r_state == FILL);
  assign bus.overflow   = r_overflow;
  assign bus.valid_beta = r_vld_p1;
  assign bus.last_beta  = r_last_p1;
  assign bus.beta_idx   = r_idx_p1;
  assign bus.beta_0     = r_beta_p1[0];
  assign bus.beta_1     = r_beta_p1[1];
  assign bus.beta_2     = r_beta_p1[2];
  assign bus.beta_3     = r_beta_p1[3];
  assign bus.beta_4     = r_beta_p1[4];
  assign bus.beta_5     = r_beta_p1[5];
  assign bus.beta_6     = r_beta_p1[6];
  assign bus.beta_7     = r_beta_p1[7];
endmodule

// File: tb/tb_beta_lifo.sv
// tb_beta_lifo: directed bench for beta_lifo (table of 2-step blocks plus
// hand-written multi-cycle sequences). Expected metrics follow BETA_NORM_EN.
module tb_beta_lifo;
  localparam int ADDR_W  = 13;
  localparam int MAX_LEN = 6144;

  logic clk = 1'b0;
  logic rst = 1'b0;

  beta_lifo_if #(.ADDR_W(ADDR_W)) bus ();

  beta_lifo #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic [7:0][15:0]  b;
  } out_t;

  typedef struct {
    int g1;
    int g2;
    int e[8];
  } vec_t;

  out_t q[$];
  vec_t tbl[5];
  int   n_total = 0;
  int   n_bad   = 0;
  int   fg1[16];
  int   fg2[16];
  int   exp_b[8];

  // Output monitor, sampled 1 ns after the rising edge.
  always @(posedge clk) begin
    out_t o;
    #1;
    if (bus.valid_beta) begin
      o.idx  = bus.beta_idx;
      o.last = bus.last_beta;
      o.b[0] = bus.beta_0; o.b[1] = bus.beta_1; o.b[2] = bus.beta_2; o.b[3] = bus.beta_3;
      o.b[4] = bus.beta_4; o.b[5] = bus.beta_5; o.b[6] = bus.beta_6; o.b[7] = bus.beta_7;
      q.push_back(o);
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_init();
    exp_b[0] = 0;
    for (int i = 1; i < 8; i++) exp_b[i] = -128;
  endtask

  task automatic set_exp(input int e0, input int e1, input int e2, input int e3,
                         input int e4, input int e5, input int e6, input int e7);
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
    exp_b[4] = e4; exp_b[5] = e5; exp_b[6] = e6; exp_b[7] = e7;
  endtask

  task automatic check_rec(input string nm, input int pos, input int idx, input int last);
    if (q.size() <= pos) begin
      check({nm, "_present"}, q.size(), pos + 1);
    end else begin
      check({nm, "_idx"}, int'(q[pos].idx), idx);
      check({nm, "_last"}, int'(q[pos].last), last);
      for (int i = 0; i < 8; i++)
        check($sformatf("%s_b%0d", nm, i), int'($signed(q[pos].b[i])), exp_b[i]);
    end
  endtask

  // Push n steps from fg1/fg2 (zeros beyond 16); waits on ready_in before each.
  task automatic feed(input int n, input bit use_last, input bit hold);
    int guard;
    for (int k = 0; k < n; k++) begin
      bus.valid_branch = 1'b1;
      bus.init_branch1 = 16'((k < 16) ? fg1[k] : 0);
      bus.init_branch2 = 16'((k < 16) ? fg2[k] : 0);
      bus.last_branch  = use_last && (k == n - 1);
      guard = 0;
      while (!bus.ready_in && guard < 20000) begin
        tick();
        guard++;
      end
      if (!bus.ready_in) check("feed_ready_timeout", int'(bus.ready_in), 1);
      tick();
    end
    if (!hold) begin
      bus.valid_branch = 1'b0;
      bus.last_branch  = 1'b0;
    end
  endtask

  task automatic wait_outs(input int n, input string nm);
    int guard = 0;
    while (!(q.size() >= n && bus.ready_in) && guard < 20000) begin
      tick();
      guard++;
    end
    check({nm, "_done"}, int'(q.size() >= n && bus.ready_in), 1);
  endtask

  initial begin
    int seq_err;
    bus.valid_branch = 1'b0;
    bus.last_branch  = 1'b0;
    bus.init_branch1 = '0;
    bus.init_branch2 = '0;
    for (int i = 0; i < 16; i++) begin fg1[i] = 0; fg2[i] = 0; end

`ifdef BETA_NORM_EN
    tbl[0] = '{10, 0,     '{0, -20, -138, -138, -138, -138, -128, -128}};
    tbl[1] = '{-20, 7,    '{0, 40, -101, -101, -101, -101, -88, -88}};
    tbl[2] = '{100, -30,  '{0, -128, -198, -198, -198, -198, -128, -128}};
    tbl[3] = '{-100, 0,   '{0, 128, -100, -100, -100, -100, 0, 0}};
    tbl[4] = '{32767, 0,  '{0, -128, 32641, 32641, 32641, 32641, -126, -126}};
`else
    tbl[0] = '{10, 0,     '{10, -10, -128, -128, -128, -128, -118, -118}};
    tbl[1] = '{-20, 7,    '{-20, 20, -121, -121, -121, -121, -108, -108}};
    tbl[2] = '{100, -30,  '{100, -28, -98, -98, -98, -98, -28, -28}};
    tbl[3] = '{-100, 0,   '{-28, 100, -128, -128, -128, -128, -28, -28}};
    tbl[4] = '{32767, 0,  '{32767, 32639, -128, -128, -128, -128, 32641, 32641}};
`endif

    // Reset state.
    #12;
    check("rst_ready", int'(bus.ready_in), 1);
    check("rst_valid", int'(bus.valid_beta), 0);
    check("rst_last", int'(bus.last_beta), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_idx", int'(bus.beta_idx), 0);
    check("rst_b1", int'(bus.beta_1), 0);
    rst = 1'b1;
    tick();
    tick();

    // N = 1 timing: output at T+2, ready back at T+3.
    q.delete();
    fg1[0] = 10; fg2[0] = 5;
    feed(1, 1'b1, 1'b0);
    check("n1_ready_T", int'(bus.ready_in), 0);
    tick();
    check("n1_valid_T1", int'(bus.valid_beta), 0);
    tick();
    check("n1_valid_T2", int'(bus.valid_beta), 1);
    check("n1_ready_T2", int'(bus.ready_in), 0);
    tick();
    check("n1_valid_T3", int'(bus.valid_beta), 0);
    check("n1_ready_T3", int'(bus.ready_in), 1);
    check("n1_count", q.size(), 1);
    set_init();
    check_rec("n1", 0, 0, 1);

    // Table of N = 2 blocks: idx 1 = init, idx 0 = one update with step-1 gammas.
    for (int v = 0; v < 5; v++) begin
      q.delete();
      fg1[0] = 3; fg2[0] = 4;
      fg1[1] = tbl[v].g1; fg2[1] = tbl[v].g2;
      feed(2, 1'b1, 1'b0);
      wait_outs(2, $sformatf("tbl%0d", v));
      check($sformatf("tbl%0d_count", v), q.size(), 2);
      set_init();
      check_rec($sformatf("tbl%0d_k1", v), 0, 1, 0);
      for (int i = 0; i < 8; i++) exp_b[i] = tbl[v].e[i];
      check_rec($sformatf("tbl%0d_k0", v), 1, 0, 1);
    end
    check("tbl_ovf", int'(bus.overflow), 0);

    // Back-to-back blocks N=4 then N=3 with valid_branch held high.
    q.delete();
    fg1[0] = 1; fg2[0] = 2; fg1[1] = 3; fg2[1] = 4;
    fg1[2] = 5; fg2[2] = 6; fg1[3] = 7; fg2[3] = 8;
    feed(4, 1'b1, 1'b1);
    fg1[0] = 50; fg2[0] = 60; fg1[1] = 0; fg2[1] = 0;
    fg1[2] = 10; fg2[2] = 0;
    feed(3, 1'b1, 1'b0);
    wait_outs(7, "b2b");
    check("b2b_count", q.size(), 7);
    set_init();
    check_rec("b2b_a3", 0, 3, 0);
    if (q.size() >= 7) begin
      check("b2b_a2_idx", int'(q[1].idx), 2);
      check("b2b_a1_idx", int'(q[2].idx), 1);
      check("b2b_a0_idx", int'(q[3].idx), 0);
      check("b2b_a0_last", int'(q[3].last), 1);
      check("b2b_a2_last", int'(q[1].last), 0);
    end
    check_rec("b2b_b2", 4, 2, 0);
`ifdef BETA_NORM_EN
    set_exp(0, -20, -138, -138, -138, -138, -128, -128);
`else
    set_exp(10, -10, -128, -128, -128, -128, -118, -118);
`endif
    check_rec("b2b_b1", 5, 1, 0);
`ifdef BETA_NORM_EN
    set_exp(0, 0, -20, -20, -128, -128, -128, -128);
`else
    set_exp(10, 10, -10, -10, -118, -118, -118, -118);
`endif
    check_rec("b2b_b0", 6, 0, 1);

    // Overflow: MAX_LEN accepts without last_branch.
    q.delete();
    for (int i = 0; i < 16; i++) begin fg1[i] = 0; fg2[i] = 0; end
    feed(MAX_LEN - 1, 1'b0, 1'b1);
    check("ovf_before", int'(bus.overflow), 0);
    check("ovf_ready_before", int'(bus.ready_in), 1);
    feed(1, 1'b0, 1'b1);
    check("ovf_after", int'(bus.overflow), 1);
    check("ovf_ready_after", int'(bus.ready_in), 0);
    bus.last_branch = 1'b1;
    wait_outs(MAX_LEN, "ovf_drain");
    tick();
    bus.valid_branch = 1'b0;
    bus.last_branch  = 1'b0;
    wait_outs(MAX_LEN + 1, "ovf_next");
    check("ovf_count", q.size(), MAX_LEN + 1);
    seq_err = 0;
    if (q.size() >= MAX_LEN) begin
      for (int i = 0; i < MAX_LEN; i++)
        if (int'(q[i].idx) != MAX_LEN - 1 - i || q[i].last != (i == MAX_LEN - 1)) seq_err++;
    end
    check("ovf_seq_errors", seq_err, 0);
    set_init();
    check_rec("ovf_nextblk", MAX_LEN, 0, 1);
    check("ovf_sticky", int'(bus.overflow), 1);

    // Reset in the middle of DRAIN after 3 outputs of an N=10 block.
    q.delete();
    for (int i = 0; i < 10; i++) begin fg1[i] = i + 1; fg2[i] = 2 * i; end
    feed(10, 1'b1, 1'b0);
    begin
      int guard = 0;
      while (q.size() < 3 && guard < 100) begin tick(); guard++; end
    end
    check("mid_outs_before_rst", q.size(), 3);
    check("mid_idx2", (q.size() >= 3) ? int'(q[2].idx) : -1, 7);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.valid_beta), 0);
    check("mid_rst_last", int'(bus.last_beta), 0);
    check("mid_rst_ready", int'(bus.ready_in), 1);
    check("mid_rst_ovf", int'(bus.overflow), 0);
    check("mid_rst_idx", int'(bus.beta_idx), 0);
    check("mid_rst_b0", int'(bus.beta_0), 0);
    check("mid_rst_b7", int'(bus.beta_7), 0);
    #3;
    rst = 1'b1;
    tick();
    q.delete();
    fg1[0] = 7; fg2[0] = -3;
    feed(1, 1'b1, 1'b0);
    wait_outs(1, "post_rst");
    check("post_rst_count", q.size(), 1);
    set_init();
    check_rec("post_rst", 0, 0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/beta_lifo.md
# beta_lifo

- Backward-recursion (beta) unit of the max-log-MAP SISO decoder; the reverse-direction counterpart of the forward alpha recursion.
- Stores the per-step branch-metric pair of one code block in an internal LIFO while the block streams in.
- On the block's last step, it replays the metrics in reverse and runs the 8-state beta recursion.
- It emits one normalized state-metric vector per trellis step, tagged with the step index, for the LLR stage.

## Interface
- MAX_LEN, 6144, maximum trellis steps per block (LIFO depth)
- ADDR_W, 13, LIFO address / step-index width; must satisfy 2^ADDR_W >= MAX_LEN
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- valid_branch  in  1  branch-metric pair valid this cycle
- init_branch1  in  16  gamma1, signed two's complement
- init_branch2  in  16  gamma2, signed two's complement
- last_branch  in  1  qualifies valid_branch: final trellis step of block
- ready_in  out  1  block accepts branch metrics; accept = valid_branch & ready_in
- beta_0 .. beta_7  out  16 each  state metrics for the emitted step, signed
- beta_idx  out  ADDR_W  trellis step k of the current output
- valid_beta  out  1  beta_*/beta_idx valid
- last_beta  out  1  marks output for k = 0
- overflow  out  1  sticky: block hit MAX_LEN without last_branch

## Operation
- States:
  - FILL (reset state): each accept writes {gamma1, gamma2} at wr_ptr, then wr_ptr++.
  - An accept with last_branch, or the accept that fills entry MAX_LEN-1 (also sets overflow), latches N = wr_ptr+1 and moves to DRAIN.
  - DRAIN: reads addresses N-1 down to 0 on consecutive cycles, one per cycle, with a synchronous RAM of 1-cycle read latency.
  - After the output for k = 0, the block returns to FILL with wr_ptr = 0.
- Beta register init on DRAIN entry (terminated trellis): b0 = 0, b1..b7 = -128.
- For step k with gammas (g1, g2), the output is the current register (beta_{k+1}). The register then updates, all terms max with signed strict >, ties selecting the second term:
  - b0 = max(b0+g1, b4-g1); b1 = max(b0-g1, b4+g1)
  - b2 = max(b1-g2, b5+g2); b3 = max(b1+g2, b5-g2)
  - b4 = max(b2+g2, b6-g2); b5 = max(b2-g2, b6+g2)
  - b6 = max(b3-g1, b7+g1); b7 = max(b3+g1, b7-g1)
- Arithmetic: 16-bit, wrap-around, no saturation. Comparisons are signed on the 16-bit wrapped sums.
- Normalization (see Configuration): the new b0 is subtracted from all eight new values before they are registered, so stored b0 is always 0.
- valid_branch while ready_in = 0 is ignored; no write, no error.
- last_branch without valid_branch is ignored.
- overflow clears only on reset.
- Reset (any time, including mid-DRAIN): state FILL, pointers 0, beta registers re-initialized. Outputs on reset:
  - beta_*, beta_idx, valid_beta, last_beta, overflow = 0
  - ready_in = 1

## Timing
- Accept at edge T of the last step: ready_in is 0 from after edge T.
- First valid_beta (k = N-1, init values) is registered at edge T+2.
- Outputs k = N-1 .. 0 follow on N consecutive cycles with no bubbles; valid_beta is continuous.
- last_beta = 1 together with k = 0, on the output registered at edge T+N+1.
- At edge T+N+2: valid_beta and last_beta drop, and ready_in returns to 1.
- No output backpressure; the consumer must accept every valid_beta cycle.
- Input latency of FILL is 0; back-to-back accepts every cycle are allowed.

## Configuration
- BETA_NORM_EN defined: per-step subtraction of the new b0 from all metrics, as above.
- Not defined: raw recursion values are registered and output. Values wrap modulo 2^16, and b0 is not forced to 0.

## Test plan
- Reset mid-DRAIN (assert rst after 3 outputs of an N=10 block) -> valid_beta, last_beta, and all outputs = 0, and ready_in = 1 immediately. A new N=1 block then gives init values.
- N=1, (g1, g2) = (10, 5) -> single output at T+2: b0 = 0, b1..b7 = -128, beta_idx = 0, last_beta = 1. ready_in = 1 at T+3.
- N=2, step0 = (3, 4), step1 = (10, 0), BETA_NORM_EN -> two outputs:
  - idx 1: init values
  - idx 0: (0, -20, -138, -138, -138, -138, -128, -128), with last_beta only on idx 0
- Same stimulus without BETA_NORM_EN -> idx 0 outputs (10, -10, -128, -128, -128, -128, -118, -118).
- Stream of MAX_LEN accepts with no last_branch -> overflow = 1 after the final accept, and DRAIN emits MAX_LEN outputs. valid_branch during DRAIN is ignored, and the next block starts at index 0.
- Two back-to-back blocks (N=4, N=3), valid_branch held high -> no accepts while ready_in = 0. Output indices run 3, 2, 1, 0, then 2, 1, 0, each block starting from init metrics.
